// File: rtl/isp_tpg_if.sv
// Video stream produced by the test-pattern generator.
// Carries the line/frame qualifiers and one RGB pixel per pclk.
interface isp_tpg_if #(
   parameter int BITS = 8
);
   logic            href;
   logic            vsync;
   logic [BITS-1:0] r;
   logic [BITS-1:0] g;
   logic [BITS-1:0] b;

   modport master (output href, vsync, r, g, b);
   modport slave  (input  href, vsync, r, g, b);
endinterface

// File: rtl/isp_tpg.sv
// Test-pattern generator and video-timing source at the head of the ISP pipeline.
// Emits vsync/href/RGB frames with programmable blanking and four patterns.
module isp_tpg #(
   parameter int BITS        = 8,
   parameter int WIDTH       = 1280,
   parameter int HEIGHT      = 960,
   parameter int HBLANK      = 160,
   parameter int VSYNC_LINES = 2,
   parameter int VBP         = 2,
   parameter int VFP         = 2
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       pattern,
   input  logic [BITS-1:0]  sol_r,
   input  logic [BITS-1:0]  sol_g,
   input  logic [BITS-1:0]  sol_b,
   isp_tpg_if.master        vid,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      frame_cnt
);

   localparam int LP  = WIDTH + HBLANK;
   localparam int FL  = VSYNC_LINES + VBP + HEIGHT + VFP;
   localparam int HW  = $clog2(LP + 1);
   localparam int VW  = $clog2(FL + 1);
   localparam int BW  = WIDTH / 8;
   localparam int BPW = (BW > 1) ? $clog2(BW) : 1;

   localparam logic [HW-1:0]  H_LAST    = HW'(LP - 1);
   localparam logic [HW-1:0]  H_ACT     = HW'(WIDTH);
   localparam logic [HW-1:0]  H_BIT5    = HW'(32);
   localparam logic [VW-1:0]  V_LAST    = VW'(FL - 1);
   localparam logic [VW-1:0]  V_SYNC    = VW'(VSYNC_LINES);
   localparam logic [VW-1:0]  V_ACT0    = VW'(VSYNC_LINES + VBP);
   localparam logic [VW-1:0]  V_ACT_END = VW'(VSYNC_LINES + VBP + HEIGHT);
   localparam logic [VW-1:0]  V_BIT5    = VW'(32);
   localparam logic [BPW-1:0] BAR_LAST  = BPW'(BW - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_SOLID = 2'd2,
      PAT_CHECK = 2'd3
   } pat_e;

   state_e          state_q;
   logic [HW-1:0]   h_q;
   logic [VW-1:0]   v_q;
   logic [2:0]      bar_idx_q;
   logic [BPW-1:0]  bar_pos_q;
   pat_e            pat_q;
   logic [BITS-1:0] sol_r_q, sol_g_q, sol_b_q;

   logic            href_q, vsync_q, busy_q, done_q;
   logic [BITS-1:0] r_q, g_q, b_q;
   logic [15:0]     frame_cnt_q;

   logic            emit;
   logic            frame_start;
   logic            last_pix;
   logic            act_line;
   logic            chk;
   logic [VW-1:0]   y_v;
   logic            href_d, vsync_d;
   logic [BITS-1:0] pix_r, pix_g, pix_b;
   logic [BITS-1:0] r_d, g_d, b_d;

   // IDLE always parks the counters at h=v=0, so an enable seen there emits
   // the first vsync pixel on the very same edge that enters RUN.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      emit        = (state_q == S_RUN) || enable;
      frame_start = emit && (h_q == '0) && (v_q == '0);
      last_pix    = (h_q == H_LAST) && (v_q == V_LAST);
      act_line    = (v_q >= V_ACT0) && (v_q < V_ACT_END);
      y_v         = v_q - V_ACT0;
      chk         = (|(h_q & H_BIT5)) ^ (|(y_v & V_BIT5));
      vsync_d     = emit && (v_q < V_SYNC);
      href_d      = emit && act_line && (h_q < H_ACT);

      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (pat_q)
         PAT_BARS: begin
            // Bar order white..black maps to inverted index bits.
            pix_r = {BITS{~bar_idx_q[1]}};
            pix_g = {BITS{~bar_idx_q[2]}};
            pix_b = {BITS{~bar_idx_q[0]}};
         end
         PAT_RAMP: begin
            pix_r = BITS'(h_q);
            pix_g = BITS'(h_q);
            pix_b = BITS'(h_q);
         end
         PAT_SOLID: begin
            pix_r = sol_r_q;
            pix_g = sol_g_q;
            pix_b = sol_b_q;
         end
         PAT_CHECK: begin
            pix_r = {BITS{chk}};
            pix_g = {BITS{chk}};
            pix_b = {BITS{chk}};
         end
         default: ;
      endcase

      r_d = href_d ? pix_r : '0;
      g_d = href_d ? pix_g : '0;
      b_d = href_d ? pix_b : '0;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         v_q         <= '0;
         bar_idx_q   <= '0;
         bar_pos_q   <= '0;
         pat_q       <= PAT_BARS;
         sol_r_q     <= '0;
         sol_g_q     <= '0;
         sol_b_q     <= '0;
         href_q      <= 1'b0;
         vsync_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         frame_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         href_q  <= href_d;
         vsync_q <= vsync_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         busy_q  <= emit;
         done_q  <= emit && last_pix;

         if (emit && last_pix)
            frame_cnt_q <= frame_cnt_q + 16'd1;

         if (frame_start) begin
            pat_q   <= pat_e'(pattern);
            sol_r_q <= sol_r;
            sol_g_q <= sol_g;
            sol_b_q <= sol_b;
         end

         if (emit) begin
            if (state_q == S_IDLE)
               state_q <= S_RUN;

            if (h_q == H_LAST) begin
               h_q <= '0;
               if (v_q == V_LAST) begin
                  v_q     <= '0;
                  state_q <= enable ? S_RUN : S_IDLE;
               end else begin
                  v_q <= v_q + VW'(1);
               end
            end else begin
               h_q <= h_q + HW'(1);
            end

            // Bar tracker follows h without a divider: WIDTH/8 pixels per bar.
            if (h_q == H_LAST) begin
               bar_idx_q <= '0;
               bar_pos_q <= '0;
            end else if (bar_pos_q == BAR_LAST) begin
               bar_pos_q <= '0;
               bar_idx_q <= bar_idx_q + 3'd1;
            end else begin
               bar_pos_q <= bar_pos_q + BPW'(1);
            end
         end
      end
   end

   assign vid.href   = href_q;
   assign vid.vsync  = vsync_q;
   assign vid.r      = r_q;
   assign vid.g      = g_q;
   assign vid.b      = b_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_isp_tpg.sv
// Bench for isp_tpg: small-frame DUT (LP=20, FL=7) plus a WIDTH=1280 DUT
// for the 32x32 checkerboard edges.
module tb_isp_tpg;

   localparam int LP  = 20;
   localparam int FP  = 140;
   localparam int BLP = 1284;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern = 2'd0;
   logic [7:0]  sol_r = 8'h00, sol_g = 8'h00, sol_b = 8'h00;
   logic        busy, frame_done;
   logic [15:0] frame_cnt;

   logic        enable_b = 1'b0;
   logic        busy_b, done_b;
   logic [15:0] cnt_b;

   isp_tpg_if #(.BITS(8)) vid   ();
   isp_tpg_if #(.BITS(8)) vid_b ();

   isp_tpg #(
      .BITS(8), .WIDTH(16), .HEIGHT(4), .HBLANK(4),
      .VSYNC_LINES(1), .VBP(1), .VFP(1)
   ) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
      .sol_r(sol_r), .sol_g(sol_g), .sol_b(sol_b), .vid(vid),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   isp_tpg #(
      .BITS(8), .WIDTH(1280), .HEIGHT(33), .HBLANK(4),
      .VSYNC_LINES(1), .VBP(1), .VFP(1)
   ) dut_big (
      .pclk(pclk), .rst_n(rst_n), .enable(enable_b), .pattern(2'd3),
      .sol_r(8'h00), .sol_g(8'h00), .sol_b(8'h00), .vid(vid_b),
      .busy(busy_b), .frame_done(done_b), .frame_cnt(cnt_b)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      string      name;
      logic [1:0] pat;
      logic [7:0] sr, sg, sb;
      int         cyc;
      logic       href, vs;
      logic [7:0] r, g, b;
      logic       done;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [1:0] p, input logic [7:0] sr, sg, sb,
                      input int c, input logic hr, vs, input logic [7:0] r, g, b, input logic d);
      vec_t t;
      t.name = nm; t.pat = p; t.sr = sr; t.sg = sg; t.sb = sb; t.cyc = c;
      t.href = hr; t.vs = vs; t.r = r; t.g = g; t.b = b; t.done = d;
      vq.push_back(t);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300 && busy; k++) @(negedge pclk);
      check("idle_reached", 32'(busy), 32'd0);
      @(negedge pclk);
   endtask

   // Reference for output cycle c (1-based) of one small frame.
   function automatic logic [25:0] model(input int c, input logic [1:0] pat,
                                         input logic [7:0] sr, sg, sb);
      int idx, h, v, bar;
      logic hr, vs;
      logic [7:0] r, g, b;
      idx = c - 1;
      h   = idx % LP;
      v   = idx / LP;
      vs  = (v == 0);
      hr  = (v >= 2) && (v <= 5) && (h < 16);
      r = 8'h00; g = 8'h00; b = 8'h00;
      if (hr) begin
         case (pat)
            2'd0: begin
               bar = h / 2;
               r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
               g = (bar < 4) ? 8'hFF : 8'h00;
               b = (bar % 2 == 0) ? 8'hFF : 8'h00;
            end
            2'd1: begin r = 8'(h); g = r; b = r; end
            2'd2: begin r = sr; g = sg; b = sb; end
            default: begin
               r = (((h / 32) + ((v - 2) / 32)) % 2 == 1) ? 8'hFF : 8'h00;
               g = r; b = r;
            end
         endcase
      end
      return {hr, vs, r, g, b};
   endfunction

   logic [25:0] exp_pix;
   logic        prev_hr, prev_vs, busy_s;
   logic [15:0] cnt0, cnt_s;
   int n_vs, n_hr, n_burst, pix_err, n_done, done_at, n_rise, busy_gap;
   int err1, err2, n_solid, quiet, err0, err32, n0, n32, bidx, bh, bv;
   int rise[4];
   logic [7:0] e;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Directed vectors: single frame each, sampled at output cycle cyc.
      add("ramp_vsync_first", 2'd1, 8'h00, 8'h00, 8'h00,   1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_vsync_last",  2'd1, 8'h00, 8'h00, 8'h00,  20, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_vbp",         2'd1, 8'h00, 8'h00, 8'h00,  21, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_x0_y0",       2'd1, 8'h00, 8'h00, 8'h00,  41, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_x15_y0",      2'd1, 8'h00, 8'h00, 8'h00,  56, 1'b1, 1'b0, 8'h0F, 8'h0F, 8'h0F, 1'b0);
      add("ramp_hblank",      2'd1, 8'h00, 8'h00, 8'h00,  57, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_x9_y3",       2'd1, 8'h00, 8'h00, 8'h00, 110, 1'b1, 1'b0, 8'h09, 8'h09, 8'h09, 1'b0);
      add("ramp_vfp",         2'd1, 8'h00, 8'h00, 8'h00, 125, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_no_done_139", 2'd1, 8'h00, 8'h00, 8'h00, 139, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("ramp_done_140",    2'd1, 8'h00, 8'h00, 8'h00, 140, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      add("bar_white",        2'd0, 8'h00, 8'h00, 8'h00,  41, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      add("bar_yellow",       2'd0, 8'h00, 8'h00, 8'h00,  43, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0);
      add("bar_cyan",         2'd0, 8'h00, 8'h00, 8'h00,  46, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0);
      add("bar_green",        2'd0, 8'h00, 8'h00, 8'h00,  47, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
      add("bar_magenta",      2'd0, 8'h00, 8'h00, 8'h00,  49, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0);
      add("bar_red",          2'd0, 8'h00, 8'h00, 8'h00,  51, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
      add("bar_blue",         2'd0, 8'h00, 8'h00, 8'h00,  53, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
      add("bar_black",        2'd0, 8'h00, 8'h00, 8'h00,  56, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("bar_white_y2",     2'd0, 8'h00, 8'h00, 8'h00,  81, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      add("solid_x0_y0",      2'd2, 8'h12, 8'h34, 8'h56,  41, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0);
      add("solid_x14_y1",     2'd2, 8'h12, 8'h34, 8'h56,  75, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56, 1'b0);
      add("solid_hblank",     2'd2, 8'h12, 8'h34, 8'h56,  78, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      add("check_small",      2'd3, 8'h00, 8'h00, 8'h00,  45, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

      // Reset state.
      repeat (2) @(negedge pclk);
      check("reset_outputs", 32'({vid.href, vid.vsync, vid.r, vid.g, vid.b, busy, frame_done}), 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge pclk);

      // One-cycle enable pulse, ramp: exactly one frame.
      pattern = 2'd1; enable = 1'b1;
      n_vs = 0; n_hr = 0; n_burst = 0; pix_err = 0; n_done = 0; done_at = 0; prev_hr = 1'b0;
      cnt_s = '0; busy_s = 1'b1;
      for (int c = 1; c <= 160; c++) begin
         @(negedge pclk);
         if (c == 1) enable = 1'b0;
         if (vid.vsync) n_vs++;
         if (vid.href) begin
            n_hr++;
            if (!prev_hr) n_burst++;
         end
         prev_hr = vid.href;
         exp_pix = (c <= FP) ? model(c, 2'd1, 8'h00, 8'h00, 8'h00) : 26'd0;
         if ({vid.href, vid.vsync, vid.r, vid.g, vid.b} !== exp_pix) pix_err++;
         if (frame_done) begin n_done++; done_at = c; end
         if (c == FP) cnt_s = frame_cnt;
         if (c == FP + 1) busy_s = busy;
      end
      check("single_vsync_cycles", 32'(n_vs), 32'd20);
      check("single_href_cycles", 32'(n_hr), 32'd64);
      check("single_href_bursts", 32'(n_burst), 32'd4);
      check("single_ramp_pixels", 32'(pix_err), 32'd0);
      check("single_done_count", 32'(n_done), 32'd1);
      check("single_done_cycle", 32'(done_at), 32'd140);
      check("single_frame_cnt", 32'(cnt_s), 32'd1);
      check("single_busy_after", 32'(busy_s), 32'd0);

      // Table-driven vectors.
      foreach (vq[i]) begin
         pattern = vq[i].pat; sol_r = vq[i].sr; sol_g = vq[i].sg; sol_b = vq[i].sb;
         enable = 1'b1;
         @(negedge pclk);
         enable = 1'b0;
         repeat (vq[i].cyc - 1) @(negedge pclk);
         check(vq[i].name,
               32'({vid.href, vid.vsync, vid.r, vid.g, vid.b, frame_done}),
               32'({vq[i].href, vq[i].vs, vq[i].r, vq[i].g, vq[i].b, vq[i].done}));
         wait_idle();
      end

      // Back-to-back frames with enable held.
      cnt0 = frame_cnt; pattern = 2'd1; enable = 1'b1;
      n_rise = 0; busy_gap = 0; prev_vs = 1'b0;
      for (int k = 0; k < 4; k++) rise[k] = 0;
      for (int c = 1; c <= 440; c++) begin
         @(negedge pclk);
         if (c == 290) enable = 1'b0;
         if (vid.vsync && !prev_vs) begin
            if (n_rise < 4) rise[n_rise] = c;
            n_rise++;
         end
         prev_vs = vid.vsync;
         if (c <= 3 * FP && !busy) busy_gap++;
      end
      check("b2b_vsync_rises", 32'(n_rise), 32'd3);
      check("b2b_period_1", 32'(rise[1] - rise[0]), 32'd140);
      check("b2b_period_2", 32'(rise[2] - rise[1]), 32'd140);
      check("b2b_busy_gaps", 32'(busy_gap), 32'd0);
      check("b2b_frame_cnt", 32'(16'(frame_cnt - cnt0)), 32'd3);
      wait_idle();

      // Pattern/solid change mid-frame applies to the next frame only.
      pattern = 2'd2; sol_r = 8'h12; sol_g = 8'h34; sol_b = 8'h56; enable = 1'b1;
      err1 = 0; err2 = 0; n_solid = 0;
      for (int c = 1; c <= 2 * FP; c++) begin
         @(negedge pclk);
         if (c <= FP) begin
            exp_pix = model(c, 2'd2, 8'h12, 8'h34, 8'h56);
            if ({vid.href, vid.vsync, vid.r, vid.g, vid.b} !== exp_pix) err1++;
            if (vid.href && {vid.r, vid.g, vid.b} === 24'h123456) n_solid++;
         end else begin
            exp_pix = model(c - FP, 2'd1, 8'h00, 8'h00, 8'h00);
            if ({vid.href, vid.vsync, vid.r, vid.g, vid.b} !== exp_pix) err2++;
         end
         if (c == 70) begin
            pattern = 2'd1; sol_r = 8'hAA; sol_g = 8'hBB; sol_b = 8'hCC;
         end
         if (c == 150) enable = 1'b0;
      end
      check("latch_frame1_solid", 32'(err1), 32'd0);
      check("latch_frame1_pixels", 32'(n_solid), 32'd64);
      check("latch_frame2_ramp", 32'(err2), 32'd0);
      wait_idle();

      // Enable dropped mid-frame: the frame still completes.
      pattern = 2'd1; enable = 1'b1; done_at = 0; busy_s = 1'b1;
      for (int c = 1; c <= 160; c++) begin
         @(negedge pclk);
         if (c == 70) enable = 1'b0;
         if (frame_done) done_at = c;
         if (c == FP + 1) busy_s = busy;
      end
      check("drop_done_cycle", 32'(done_at), 32'd140);
      check("drop_busy_falls", 32'(busy_s), 32'd0);
      check("drop_idle_vsync", 32'({busy, vid.vsync}), 32'd0);

      // Second run, async reset mid-frame.
      enable = 1'b1;
      @(negedge pclk);
      enable = 1'b0;
      repeat (49) @(negedge pclk);
      check("pre_reset_pixel", 32'({vid.href, vid.r}), 32'h109);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'({vid.href, vid.vsync, vid.r, vid.g, vid.b, busy, frame_done}), 32'd0);
      check("async_reset_cnt", 32'(frame_cnt), 32'd0);
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      quiet = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge pclk);
         if (busy || vid.vsync || vid.href) quiet++;
      end
      check("post_reset_quiet", 32'(quiet), 32'd0);
      enable = 1'b1;
      @(negedge pclk);
      enable = 1'b0;
      check("restart_vsync_busy", 32'({busy, vid.vsync}), 32'h3);
      wait_idle();

      // Enable held through reset release.
      enable = 1'b1; rst_n = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      @(negedge pclk);
      enable = 1'b0;
      check("enable_thru_reset", 32'({busy, vid.vsync}), 32'h3);
      wait_idle();

      // Checkerboard at WIDTH=1280: lines y=0 and y=32, x=0..63.
      enable_b = 1'b1;
      err0 = 0; err32 = 0; n0 = 0; n32 = 0;
      for (int c = 1; c <= 35 * BLP; c++) begin
         @(negedge pclk);
         if (c == 1) enable_b = 1'b0;
         bidx = c - 1;
         bh = bidx % BLP;
         bv = bidx / BLP;
         if ((bv == 2 || bv == 34) && bh < 64) begin
            e = ((bh >= 32) ^ (bv == 34)) ? 8'hFF : 8'h00;
            if ({vid_b.href, vid_b.r, vid_b.g, vid_b.b} !== {1'b1, e, e, e}) begin
               if (bv == 2) err0++;
               else err32++;
            end
            if (bv == 2) n0++;
            else n32++;
         end
      end
      check("checker_y0_pixels", 32'(err0), 32'd0);
      check("checker_y32_pixels", 32'(err32), 32'd0);
      check("checker_samples", 32'(n0 + n32), 32'd128);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/isp_tpg.md
# isp_tpg

Test-pattern generator and video-timing source for the ISP pixel pipeline. Produces the href/vsync/RGB stream that the pipeline stages (CCM, gamma, etc.) consume, with programmable blanking and four selectable patterns. It sits at the head of the pipeline in place of the sensor front-end, for bring-up and regression. It is also the stimulus source for every downstream stage's bench.

## Interface
- BITS, 8, pixel component width
- WIDTH, 1280, active pixels per line; must be a multiple of 8
- HEIGHT, 960, active lines per frame
- HBLANK, 160, blank cycles per line after active pixels (≥1)
- VSYNC_LINES, 2, lines with out_vsync=1 at frame start (≥1)
- VBP, 2, blank lines after vsync, before first active line
- VFP, 2, blank lines after last active line
- pclk  in  1  pixel clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock pclk
- enable  in  1  run request; frames start/stop only at frame boundaries
- pattern  in  2  0 colour bars, 1 ramp, 2 solid, 3 checkerboard
- sol_r, sol_g, sol_b  in  BITS each  solid colour for pattern 2
- out_href  out  1  active-pixel qualifier
- out_vsync  out  1  frame sync, high during VSYNC_LINES lines
- out_r, out_g, out_b  out  BITS each  pixel; 0 whenever out_href=0
- busy  out  1  high while a frame is being emitted
- frame_done  out  1  one-cycle pulse on last cycle of each frame
- frame_cnt  out  16  completed frames, wraps at 65535→0

## Operation
- Line period LP = WIDTH+HBLANK cycles; frame = FL = VSYNC_LINES+VBP+HEIGHT+VFP lines.
- Counters: h (0..LP-1), v (0..FL-1); h wraps to 0 and v increments at h=LP-1.
- FSM: IDLE → RUN when enable=1 sampled in IDLE (h=v=0). RUN → at h=LP-1, v=FL-1: if enable=1 wrap to h=v=0 and stay RUN (back-to-back frames, no gap); else → IDLE.
- Deasserting enable mid-frame does not truncate; the frame completes.
- out_vsync=1 for v < VSYNC_LINES (all LP cycles of those lines).
- Active line: VSYNC_LINES+VBP ≤ v < VSYNC_LINES+VBP+HEIGHT; y = v-(VSYNC_LINES+VBP). out_href=1 for h<WIDTH on active lines; x = h.
- pattern, sol_r/g/b latched at frame start (h=v=0 in RUN); changes mid-frame apply next frame.
- Pattern 0: 8 vertical bars, each WIDTH/8 wide, tracked by bar counter (no divider); order white, yellow, cyan, green, magenta, red, blue, black; components all-ones or 0.
- Pattern 1: r=g=b=x[BITS-1:0] (wraps every 2^BITS pixels).
- Pattern 2: latched sol_r/g/b.
- Pattern 3: 32×32 checkerboard, value all-ones when x[5]^y[5]=1 else 0, on all components.
- frame_cnt increments on the frame_done cycle.
- busy = 1 in RUN.

## Timing
- All outputs registered; reset value 0 for every output.
- Latency: output cycle n reflects counter state (h,v) held in cycle n-1; first out_vsync=1 cycle is the cycle after the edge sampling enable=1 in IDLE.
- frame_done and frame_cnt update appear in the output cycle corresponding to h=LP-1, v=FL-1.
- busy rises with first out_vsync cycle, falls the cycle after frame_done when stopping.
- Frame period exactly LP×FL cycles; back-to-back frames contiguous.
- Async reset mid-frame: outputs 0 immediately, FSM IDLE, counters and frame_cnt cleared; restart requires enable sampled in IDLE.
- enable=1 held through reset release: RUN entered on first edge after rst_n rises.

## Test plan
Parameters WIDTH=16, HEIGHT=4, HBLANK=4, VSYNC_LINES=1, VBP=1, VFP=1 (LP=20, FL=7, 140 cycles/frame).
- enable pulsed 1 cycle, pattern=1 -> exactly one frame: vsync high 20 cycles, 4 href bursts of 16 cycles with r=g=b=0..15, frame_done once at cycle 140, frame_cnt=1, busy low afterwards.
- enable held high 3 frames -> contiguous frames, vsync rising edges 140 cycles apart, frame_cnt=3, no idle gap.
- pattern=0 -> each active line reads bars of width 2: (FF,FF,FF),(FF,FF,00),(00,FF,FF),(00,FF,00),(FF,00,FF),(FF,00,00),(00,00,FF),(00,00,00).
- pattern=2, sol=(0x12,0x34,0x56), switch to pattern=1 mid-frame -> current frame all active pixels 0x12/0x34/0x56, next frame ramp; blanking pixels 0.
- enable dropped at mid-frame -> frame completes, frame_done, IDLE; rst_n pulsed low mid-frame on second run -> all outputs 0 same cycle, frame_cnt=0, no output until enable re-sampled.
- WIDTH=1280, pattern=3 -> pixels x=0..31,y=0 are 0, x=32..63 are 0xFF; line y=32 inverted.
